// File: rtl/cas_pkg.sv
// Shared definitions for the cassette FSK encoder.
//   cas_state_e  : encoder FSM states
//   CAS_STEP_57M : phase step for 4800 ticks/s from a 57.272 MHz clock
//   cas_clog2    : ceiling log2 for sizing counters and pointers
package cas_pkg;

   typedef enum logic {
      CAS_IDLE = 1'b0,
      CAS_SEND = 1'b1
   } cas_state_e;

   localparam logic [23:0] CAS_STEP_57M = 24'd1406;

   function automatic int cas_clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r = r + 1;
      return r;
   endfunction

endpackage

// File: rtl/cas_byte_fifo.sv
// Small synchronous FIFO holding bytes waiting to be serialised.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset (empties the FIFO)
//   push, din    : write request and data (ignored while full)
//   pop          : read request (ignored while empty)
//   dout         : oldest entry, valid whenever empty=0
//   full, empty  : occupancy flags, derived from the registered count
module cas_byte_fifo
   import cas_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = cas_clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   // DEPTH is a power of two, so the pointers wrap naturally.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/cas_fsk_stream_encoder.sv
// Cassette FSK serialiser: bytes from a valid/ready stream are queued and
// sent back-to-back as square cycles; a '1' is a short cycle, a '0' a long
// one. Symbol timing comes from a phase accumulator whose carry is the tick.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   step         : phase increment added every enabled cycle in SEND
//   enable       : run/motor; 0 freezes transmission in place
//   in_data      : byte to send
//   in_valid     : in_data valid
//   in_ready     : FIFO has room
//   dout         : registered FSK square output
//   busy         : 1 while in SEND
//   byte_done    : one-cycle pulse when the last bit of a byte completes
//   state_dbg    : current FSM state
//
// Handshake: a byte transfers on every rising edge where in_valid and
// in_ready are both 1. in_ready depends only on the registered FIFO count,
// so a pop on the same edge does not make room for a push; the producer
// keeps in_valid and in_data steady until the transfer happens.
module cas_fsk_stream_encoder
   import cas_pkg::*;
#(
   parameter int   ACC_W      = 24,
   parameter int   DATA_W     = 8,
   parameter int   FIFO_DEPTH = 4,
   parameter int   ONE_TICKS  = 2,
   parameter int   ZERO_TICKS = 4,
   parameter int   LSB_FIRST  = 1,
   parameter logic IDLE_LEVEL = 1'b0
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [ACC_W-1:0]  step,
   input  logic              enable,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              dout,
   output logic              busy,
   output logic              byte_done,
   output cas_state_e        state_dbg
);

   localparam int MAX_T = (ONE_TICKS > ZERO_TICKS) ? ONE_TICKS : ZERO_TICKS;
   localparam int SYM_W = cas_clog2(MAX_T + 1);
   localparam int BIT_W = (DATA_W > 1) ? cas_clog2(DATA_W) : 1;

   localparam logic [SYM_W-1:0] ONE_T    = SYM_W'(ONE_TICKS);
   localparam logic [SYM_W-1:0] ZERO_T   = SYM_W'(ZERO_TICKS);
   localparam logic [SYM_W-1:0] ONE_H    = SYM_W'(ONE_TICKS / 2);
   localparam logic [SYM_W-1:0] ZERO_H   = SYM_W'(ZERO_TICKS / 2);
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

   cas_state_e        state, state_nx;
   logic [ACC_W-1:0]  acc, acc_nx;
   logic [ACC_W:0]    acc_sum;
   logic              tick;
   logic [SYM_W-1:0]  sym_cnt, sym_nx, sym_inc;
   logic [SYM_W-1:0]  bit_t, bit_half;
   logic [BIT_W-1:0]  bit_idx, bit_nx;
   logic [DATA_W-1:0] shifter, shifter_nx, shifted;
   logic              cur_bit;
   logic              dout_nx;
   logic              byte_done_nx;

   logic              fifo_push;
   logic              fifo_pop;
   logic              fifo_full;
   logic              fifo_empty;
   logic [DATA_W-1:0] fifo_data;

   assign in_ready  = !fifo_full;
   assign fifo_push = in_valid && in_ready;
   assign busy      = (state == CAS_SEND);
   assign state_dbg = state;

   cas_byte_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (DATA_W)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (fifo_push),
      .din     (in_data),
      .pop     (fifo_pop),
      .dout    (fifo_data),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   // The carry out of acc+step is the symbol tick; acc wraps modulo 2^ACC_W.
   assign acc_sum  = {1'b0, acc} + {1'b0, step};
   assign tick     = acc_sum[ACC_W];
   assign sym_inc  = sym_cnt + 1'b1;
   assign cur_bit  = (LSB_FIRST != 0) ? shifter[0] : shifter[DATA_W-1];
   assign shifted  = (LSB_FIRST != 0) ? (shifter >> 1) : (shifter << 1);
   assign bit_t    = cur_bit ? ONE_T : ZERO_T;
   assign bit_half = cur_bit ? ONE_H : ZERO_H;

   always_comb begin
      state_nx     = state;
      acc_nx       = acc;
      sym_nx       = sym_cnt;
      bit_nx       = bit_idx;
      shifter_nx   = shifter;
      dout_nx      = dout;
      byte_done_nx = 1'b0;
      fifo_pop     = 1'b0;
      case (state)
         CAS_IDLE: begin
            if (enable && !fifo_empty) begin
               state_nx   = CAS_SEND;
               fifo_pop   = 1'b1;
               shifter_nx = fifo_data;
               acc_nx     = '0;
               sym_nx     = '0;
               bit_nx     = '0;
               dout_nx    = 1'b1;
            end
         end
         CAS_SEND: begin
            // With enable low nothing moves, so the waveform resumes intact.
            if (enable) begin
               acc_nx = acc_sum[ACC_W-1:0];
               if (tick) begin
                  if (sym_inc == bit_t) begin
                     sym_nx = '0;
                     if (bit_idx == LAST_BIT) begin
                        byte_done_nx = 1'b1;
                        bit_nx       = '0;
                        if (!fifo_empty) begin
                           // Next byte starts on the same edge; acc keeps
                           // running so the tick cadence is unbroken.
                           fifo_pop   = 1'b1;
                           shifter_nx = fifo_data;
                           dout_nx    = 1'b1;
                        end else begin
                           state_nx = CAS_IDLE;
                           dout_nx  = IDLE_LEVEL;
                           acc_nx   = '0;
                        end
                     end else begin
                        bit_nx     = bit_idx + 1'b1;
                        shifter_nx = shifted;
                        dout_nx    = 1'b1;
                     end
                  end else begin
                     sym_nx  = sym_inc;
                     dout_nx = (sym_inc < bit_half);
                  end
               end
            end
         end
         default: state_nx = CAS_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= CAS_IDLE;
         acc       <= '0;
         sym_cnt   <= '0;
         bit_idx   <= '0;
         shifter   <= '0;
         dout      <= IDLE_LEVEL;
         byte_done <= 1'b0;
      end else begin
         state     <= state_nx;
         acc       <= acc_nx;
         sym_cnt   <= sym_nx;
         bit_idx   <= bit_nx;
         shifter   <= shifter_nx;
         dout      <= dout_nx;
         byte_done <= byte_done_nx;
      end
   end

endmodule

// File: tb/tb_cas_fsk_stream_encoder.sv
// Directed bench for cas_fsk_stream_encoder with step=2^22 (one tick per
// 4 clk): a '1' bit lasts 8 clk (4 high), a '0' bit 16 clk (8 high).
// A negedge monitor decodes dout high-run lengths back into bytes and
// compares them against the queue of bytes the drivers pushed.
module tb_cas_fsk_stream_encoder;
   import cas_pkg::*;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [23:0] step;
   logic        enable;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic        dout;
   logic        busy;
   logic        byte_done;
   cas_state_e  state_dbg;

   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   int          done_cnt = 0;
   logic [7:0]  exp_q[$];
   int          hi_q[$];

   cas_fsk_stream_encoder dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .step      (step),
      .enable    (enable),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .dout      (dout),
      .busy      (busy),
      .byte_done (byte_done),
      .state_dbg (state_dbg)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, got, exp, cyc);
      end
   endtask

   // ---------------- scoreboard / decoder ----------------
   int         hcnt = 0;
   int         nbits = 0;
   logic [7:0] sh = '0;
   logic       prev = 1'b0;

   always @(negedge clk) begin
      if (!reset_n) begin
         hcnt = 0;
         nbits = 0;
         sh = '0;
         prev = 1'b0;
      end else begin
         if (byte_done) done_cnt++;
         if (dout) begin
            hcnt++;
         end else if (prev) begin
            hi_q.push_back(hcnt);
            sh = {(hcnt < 6), sh[7:1]};
            nbits++;
            hcnt = 0;
            if (nbits == 8) begin
               nbits = 0;
               if (exp_q.size() == 0) check("sb_underflow", 32'(exp_q.size()), 1);
               else check("sb_byte", {24'd0, sh}, {24'd0, exp_q.pop_front()});
            end
         end
         prev = dout;
      end
   end

   // ---------------- drivers ----------------
   task automatic push_byte(input logic [7:0] b, output int acc_cyc);
      int n;
      n = 0;
      @(negedge clk);
      in_data = b;
      in_valid = 1'b1;
      while (!in_ready && n < 2000) begin
         @(negedge clk);
         n++;
      end
      @(posedge clk);
      #1;
      acc_cyc = cyc;
      in_valid = 1'b0;
      exp_q.push_back(b);
   endtask

   task automatic wait_done(input int budget, output int at, output int idle_seen);
      at = -1;
      idle_seen = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (byte_done) begin
            at = cyc;
            break;
         end
         if (!busy) idle_seen++;
      end
   endtask

   task automatic wait_cyc(input int target);
      do @(negedge clk); while (cyc < target);
   endtask

   // ---------------- directed tests ----------------
   initial begin
      int e0, ld, at, idle, d0, dev;
      logic [7:0] t4_bytes [5];
      t4_bytes = '{8'h3C, 8'hC3, 8'h0F, 8'hF0, 8'h5A};
      reset_n = 1'b0;
      step = 24'h400000;
      enable = 1'b0;
      in_data = '0;
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_dout", dout, 0);
      check("rst_busy", busy, 0);
      check("rst_byte_done", byte_done, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_state", state_dbg, CAS_IDLE);
      reset_n = 1'b1;
      enable = 1'b1;

      // 1: 0xFF, latency and 8 short cycles
      push_byte(8'hFF, e0);
      @(negedge clk);
      check("t1_pre_dout", dout, 0);
      @(negedge clk);
      ld = e0 + 1;
      check("t1_lat_dout", dout, 1);
      check("t1_lat_busy", busy, 1);
      check("t1_lat_state", state_dbg, CAS_SEND);
      wait_done(200, at, idle);
      check("t1_done_cyc", at, ld + 64);
      check("t1_idle_busy", busy, 0);
      check("t1_idle_dout", dout, 0);
      @(negedge clk);
      check("t1_pulse_len", byte_done, 0);

      // 2: 0xA5, mixed bit lengths
      repeat (5) @(negedge clk);
      hi_q.delete();
      d0 = done_cnt;
      push_byte(8'hA5, e0);
      ld = e0 + 1;
      wait_done(300, at, idle);
      check("t2_done_cyc", at, ld + 96);
      repeat (20) @(negedge clk);
      check("t2_done_once", done_cnt - d0, 1);
      check("t2_nbits", hi_q.size(), 8);
      begin
         int hx [8];
         hx = '{4, 8, 4, 8, 8, 4, 8, 4};
         for (int i = 0; i < 8 && i < hi_q.size(); i++) check($sformatf("t2_high%0d", i), hi_q[i], hx[i]);
      end

      // 3: 0x01 then 0x80 with no gap
      push_byte(8'h01, e0);
      ld = e0 + 1;
      push_byte(8'h80, at);
      wait_done(400, at, idle);
      check("t3_done1_cyc", at, ld + 120);
      check("t3_idle1", idle, 0);
      check("t3_busy_mid", busy, 1);
      wait_done(400, at, idle);
      check("t3_done2_cyc", at, ld + 240);
      check("t3_idle2", idle, 0);

      // 4: fill FIFO with enable low, then release
      repeat (5) @(negedge clk);
      enable = 1'b0;
      for (int i = 0; i < 4; i++) push_byte(t4_bytes[i], e0);
      @(negedge clk);
      in_data = t4_bytes[4];
      in_valid = 1'b1;
      check("t4_full", in_ready, 0);
      check("t4_noload", busy, 0);
      @(negedge clk);
      check("t4_full_hold", in_ready, 0);
      enable = 1'b1;
      ld = cyc + 1;
      @(negedge clk);
      check("t4_load_busy", busy, 1);
      check("t4_ready_after_pop", in_ready, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      exp_q.push_back(t4_bytes[4]);
      for (int k = 1; k <= 5; k++) begin
         wait_done(300, at, idle);
         check($sformatf("t4_done%0d_cyc", k), at, ld + 96 * k);
      end

      // 5: 0x00 with a 50-cycle enable drop mid-bit
      repeat (5) @(negedge clk);
      push_byte(8'h00, e0);
      ld = e0 + 1;
      wait_cyc(ld + 20);
      check("t5_pre_dout", dout, 1);
      enable = 1'b0;
      dev = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (dout !== 1'b1 || busy !== 1'b1 || byte_done !== 1'b0) dev++;
      end
      check("t5_frozen", dev, 0);
      enable = 1'b1;
      wait_done(400, at, idle);
      check("t5_done_cyc", at, ld + 178);

      // 6: reset mid-byte with two bytes queued
      repeat (5) @(negedge clk);
      push_byte(8'h11, e0);
      ld = e0 + 1;
      push_byte(8'h22, at);
      push_byte(8'h33, at);
      wait_cyc(ld + 30);
      check("t6_pre_busy", busy, 1);
      #2 reset_n = 1'b0;
      #1;
      check("t6_rst_dout", dout, 0);
      check("t6_rst_busy", busy, 0);
      check("t6_rst_ready", in_ready, 1);
      check("t6_rst_done", byte_done, 0);
      exp_q.delete();
      d0 = done_cnt;
      repeat (3) @(negedge clk);
      #2 reset_n = 1'b1;
      dev = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (busy !== 1'b0 || in_ready !== 1'b1) dev++;
      end
      check("t6_fifo_empty", dev, 0);
      check("t6_no_done", done_cnt - d0, 0);

      check("sb_all_seen", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
